// File: rtl/mano_io_terminal.sv
// Mano machine character terminal, device side.
// Host bytes are queued in a small FIFO and handed to the CPU one at a time
// through INPR/FGI. CPU output characters are taken from OUTR when the CPU
// clears FGO, forwarded to the host over a valid/ready port, and FGO is
// re-armed after a fixed busy delay. The two directions are independent.
module mano_io_terminal #(
    parameter int par_in_depth  = 4,
    parameter int par_out_delay = 8
) (
    input  logic       io_clock,
    input  logic       io_reset,
    input  logic       io_fgi,
    input  logic       io_fgo,
    input  logic [7:0] io_outr,
    output logic       io_fgiset,
    output logic       io_fgoset,
    output logic [7:0] io_inpr,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam int PW = (par_in_depth > 1) ? $clog2(par_in_depth) : 1;
    localparam int CW = (par_out_delay > 1) ? $clog2(par_out_delay) : 1;
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(par_in_depth);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(par_out_delay - 1);

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_SET,
        IN_WAIT_SET,
        IN_WAIT_CLR
    } in_state_t;

    typedef enum logic [2:0] {
        OUT_INIT,
        OUT_ARM,
        OUT_WAIT_SET,
        OUT_WAIT_CLR,
        OUT_SEND,
        OUT_BUSY
    } out_state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [par_in_depth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    fifo_head;
    logic          push;
    logic          pop;

    // Input path
    in_state_t     in_state_q;
    logic          fgiset_q;
    logic [7:0]    inpr_q;

    // Output path
    out_state_t    out_state_q;
    logic          fgoset_q;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [CW-1:0] busy_cnt_q;

    // The FIFO is never popped while empty: IN_WAIT_CLR is only reachable
    // after a byte was taken from a non-empty FIFO, and that byte stays at
    // the head until this pop.
    assign rx_ready  = (count_q != FIFO_FULL);
    assign push      = rx_valid && rx_ready;
    assign pop       = (in_state_q == IN_WAIT_CLR) && !io_fgi;
    assign fifo_head = mem_q[rd_ptr_q];

    // Next-state for FIFO pointers and occupancy; push+pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers; reset discards any queued bytes.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO data array; contents are don't-care until written.
    always_ff @(posedge io_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Input FSM: present the FIFO head on INPR, pulse FGI set, then wait for
    // the CPU to see the flag and later clear it with INP before popping.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            in_state_q <= IN_IDLE;
            fgiset_q   <= 1'b0;
            inpr_q     <= 8'h00;
        end else begin
            fgiset_q <= 1'b0;
            case (in_state_q)
                IN_IDLE: begin
                    // A stale FGI (CPU has not read the previous character)
                    // holds the next byte back.
                    if ((count_q != '0) && !io_fgi) begin
                        inpr_q     <= fifo_head;
                        fgiset_q   <= 1'b1;
                        in_state_q <= IN_SET;
                    end
                end
                IN_SET: begin
                    in_state_q <= IN_WAIT_SET;
                end
                IN_WAIT_SET: begin
                    if (io_fgi) begin
                        in_state_q <= IN_WAIT_CLR;
                    end
                end
                IN_WAIT_CLR: begin
                    if (!io_fgi) begin
                        in_state_q <= IN_IDLE;
                    end
                end
                default: begin
                    in_state_q <= IN_IDLE;
                end
            endcase
        end
    end

    // Output FSM: announce ready with an FGO set pulse, capture OUTR when the
    // CPU clears FGO, hand the byte to the host, then stay busy before re-arming.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            out_state_q <= OUT_INIT;
            fgoset_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_cnt_q  <= '0;
        end else begin
            fgoset_q <= 1'b0;
            case (out_state_q)
                OUT_INIT: begin
                    // Leaves reset with the pulse low, then arms on the first edge.
                    fgoset_q    <= 1'b1;
                    out_state_q <= OUT_ARM;
                end
                OUT_ARM: begin
                    out_state_q <= OUT_WAIT_SET;
                end
                OUT_WAIT_SET: begin
                    if (io_fgo) begin
                        out_state_q <= OUT_WAIT_CLR;
                    end
                end
                OUT_WAIT_CLR: begin
                    // OUTR was written on the same CPU edge that cleared FGO.
                    if (!io_fgo) begin
                        tx_data_q   <= io_outr;
                        tx_valid_q  <= 1'b1;
                        out_state_q <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        busy_cnt_q  <= BUSY_LOAD;
                        out_state_q <= OUT_BUSY;
                    end
                end
                OUT_BUSY: begin
                    // Loaded with delay-1 so the pulse lands exactly
                    // par_out_delay edges after the handshake.
                    if (busy_cnt_q == '0) begin
                        fgoset_q    <= 1'b1;
                        out_state_q <= OUT_ARM;
                    end else begin
                        busy_cnt_q <= busy_cnt_q - CW'(1);
                    end
                end
                default: begin
                    out_state_q <= OUT_INIT;
                end
            endcase
        end
    end

    assign io_fgiset = fgiset_q;
    assign io_inpr   = inpr_q;
    assign io_fgoset = fgoset_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_mano_io_terminal.sv
// Bench for mano_io_terminal: directed stimulus, a small CPU flag model and
// a scoreboard monitor that checks every INPR delivery, every TX handshake
// and the cycle of every FGO set pulse.
module tb_mano_io_terminal;

    localparam int DEPTH = 4;
    localparam int DELAY = 8;
    localparam int HOLD  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_fgi;
    logic       io_fgo;
    logic [7:0] io_outr;
    logic       io_fgiset;
    logic       io_fgoset;
    logic [7:0] io_inpr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_in[$];
    logic [7:0] exp_tx[$];
    int         exp_fgo[$];

    bit in_stall     = 1'b0;
    int in_hold      = 0;
    int out_req_cnt  = 0;
    int out_done_cnt = 0;

    always #5 clk = ~clk;

    mano_io_terminal #(
        .par_in_depth (DEPTH),
        .par_out_delay(DELAY)
    ) dut (
        .io_clock (clk),
        .io_reset (rst),
        .io_fgi   (io_fgi),
        .io_fgo   (io_fgo),
        .io_outr  (io_outr),
        .io_fgiset(io_fgiset),
        .io_fgoset(io_fgoset),
        .io_inpr  (io_inpr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU flag model: FGI/FGO set on the device pulses; FGI cleared HOLD
    // cycles later (INP) unless stalled; FGO cleared when an OUT is requested.
    initial begin
        io_fgi = 1'b0;
        io_fgo = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (io_fgiset) begin
                io_fgi  = 1'b1;
                in_hold = 0;
            end else if (io_fgi && !in_stall) begin
                in_hold++;
                if (in_hold >= HOLD) io_fgi = 1'b0;
            end
            if (io_fgoset) begin
                io_fgo = 1'b1;
            end else if (io_fgo && (out_req_cnt != out_done_cnt)) begin
                io_fgo = 1'b0;
                out_done_cnt++;
            end
        end
    end

    // Scoreboard monitor
    logic [7:0] m_e8;
    int         m_ec;
    always @(negedge clk) begin
        if (!rst) begin
            if (io_fgiset) begin
                if (exp_in.size() == 0) begin
                    chk("fgiset_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e8 = exp_in.pop_front();
                    chk("inpr_at_fgiset", {24'd0, io_inpr}, {24'd0, m_e8});
                end
            end
            if (io_fgoset) begin
                if (exp_fgo.size() == 0) begin
                    chk("fgoset_unexpected", 32'd1, 32'd0);
                end else begin
                    m_ec = exp_fgo.pop_front();
                    chk("fgoset_cycle", cyc, m_ec);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e8 = exp_tx.pop_front();
                    chk("tx_data_hs", {24'd0, tx_data}, {24'd0, m_e8});
                end
                exp_fgo.push_back(cyc + DELAY + 1);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fgiset"}, {31'd0, io_fgiset}, 32'd0);
        chk({tag, "_fgoset"}, {31'd0, io_fgoset}, 32'd0);
        chk({tag, "_inpr"}, {24'd0, io_inpr}, 32'd0);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic wait_fgo_done(input int maxc, input string nm);
        int n = 0;
        while (exp_fgo.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, n < maxc}, 32'd1);
    endtask

    task automatic wait_in_drained(input int maxc, input string nm);
        int n = 0;
        while ((exp_in.size() != 0 || io_fgi) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, n < maxc}, 32'd1);
    endtask

    task automatic wait_tx_valid(input int maxc, input string nm);
        int n = 0;
        @(negedge clk);
        while (!tx_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, n < maxc}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        io_outr  = 8'h00;

        // Reset state, checked while reset is held
        @(negedge clk);
        chk_reset_outputs("rst_hold");

        // Release: one FGO set pulse on the first cycle after release
        tick();
        rst = 1'b0;
        exp_fgo.push_back(cyc + 1);
        repeat (4) begin
            @(negedge clk);
            chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        end
        wait_fgo_done(20, "reset_fgoset_timeout");

        // Single byte 8'h41: pulse exactly in cycle N+1, INPR stable until FGI falls
        tick();
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        chk("push41_ready", {31'd0, rx_ready}, 32'd1);
        exp_in.push_back(8'h41);
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("b41_fgiset_N", {31'd0, io_fgiset}, 32'd0);
        @(negedge clk);
        chk("b41_fgiset_N1", {31'd0, io_fgiset}, 32'd1);
        chk("b41_inpr_N1", {24'd0, io_inpr}, 32'h41);
        @(negedge clk);
        chk("b41_fgiset_N2", {31'd0, io_fgiset}, 32'd0);
        n = 0;
        while (io_fgi && n < 20) begin
            chk("b41_inpr_stable", {24'd0, io_inpr}, 32'h41);
            @(negedge clk);
            n++;
        end
        chk("b41_fgi_fall_timeout", {31'd0, n < 20}, 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("b41_fifo_empty_ready", {31'd0, rx_ready}, 32'd1);
        chk("b41_delivered", exp_in.size(), 32'd0);

        // Fill: 01..05 back-to-back with the CPU stalled after the first
        tick();
        in_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) tick();
            rx_data  = 8'(i);
            rx_valid = 1'b1;
            chk($sformatf("fill_ready_%0d", i), {31'd0, rx_ready}, {31'd0, i <= DEPTH});
            if (rx_ready) exp_in.push_back(8'(i));
        end
        tick();
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("fill_still_full", {31'd0, rx_ready}, 32'd0);
        tick();
        in_stall = 1'b0;
        wait_in_drained(200, "fill_drain_timeout");
        tick();
        @(negedge clk);
        chk("fill_ready_after", {31'd0, rx_ready}, 32'd1);

        // Output 8'h5A with tx_ready low for 3 cycles
        tick();
        io_outr = 8'h5A;
        exp_tx.push_back(8'h5A);
        out_req_cnt++;
        tx_ready = 1'b0;
        wait_tx_valid(20, "tx5a_valid_timeout");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("tx5a_valid_held", {31'd0, tx_valid}, 32'd1);
            chk("tx5a_data_held", {24'd0, tx_data}, 32'h5A);
        end
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        chk("tx5a_valid_cleared", {31'd0, tx_valid}, 32'd0);
        wait_fgo_done(30, "tx5a_fgoset_timeout");

        // Reset during IN_WAIT_CLR and OUT_SEND with bytes still queued
        tick();
        in_stall = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        exp_in.push_back(8'h77);
        tick();
        rx_data = 8'h88;
        tick();
        rx_data = 8'h99;
        tick();
        rx_valid = 1'b0;
        io_outr  = 8'hC3;
        out_req_cnt++;
        n = 0;
        while ((exp_in.size() != 0 || !io_fgi) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b77_present_timeout", {31'd0, n < 20}, 32'd1);
        wait_tx_valid(20, "txc3_valid_timeout");
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        exp_in.delete();
        exp_tx.delete();
        exp_fgo.delete();
        @(posedge clk);
        tick();
        rst = 1'b0;
        exp_fgo.push_back(cyc + 1);

        // Stale FGI (still 1 from the aborted byte) holds back a new byte
        tick();
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        chk("push66_ready", {31'd0, rx_ready}, 32'd1);
        exp_in.push_back(8'h66);
        tick();
        rx_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stale_no_fgiset", {31'd0, io_fgiset}, 32'd0);
        end
        tick();
        in_stall = 1'b0;
        n = 0;
        while (io_fgi && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stale_fgi_fall_timeout", {31'd0, n < 20}, 32'd1);
        chk("stale_fgiset_fall_cycle", {31'd0, io_fgiset}, 32'd0);
        @(negedge clk);
        chk("stale_fgiset_next", {31'd0, io_fgiset}, 32'd1);
        chk("stale_inpr", {24'd0, io_inpr}, 32'h66);
        wait_in_drained(60, "b66_drain_timeout");
        wait_fgo_done(30, "rst2_fgoset_timeout");
        repeat (12) @(negedge clk);

        chk("end_exp_in_empty", exp_in.size(), 32'd0);
        chk("end_exp_tx_empty", exp_tx.size(), 32'd0);
        chk("end_exp_fgo_empty", exp_fgo.size(), 32'd0);
        chk("end_tx_valid", {31'd0, tx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
